// File: rtl/output_port_arbiter_pkg.sv
// Shared types for the router output-port arbiter: flit types, lock FSM state and lock record.
package output_port_arbiter_pkg;

  localparam int unsigned NumRouterPorts = 5;
  localparam int unsigned NumVirtChn     = 2;
  localparam int unsigned VcWidth        = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;
  localparam int unsigned ReqWidth       = $clog2(NumRouterPorts);

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_st_t;

  typedef struct packed {
    arb_st_t               st;
    logic [ReqWidth-1:0]   owner;
  } s_arb_lock_t;

endpackage

// File: rtl/output_port_arbiter_rr.sv
// N-way round-robin arbiter: search starts one past ptr_i and wraps; one-hot grant plus index.
module rr_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            grant_valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IdxW'((32'(ptr_i) + off) % N);
      if (!grant_valid_o && req_i[idx]) begin
        grant_o[idx]  = 1'b1;
        grant_idx_o   = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: per-VC round-robin on HEAD flits, VC locked to its winner until TAIL.
// Optional forced unlock of stalled VCs when OUT_ARB_TIMEOUT_EN is defined.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NumRouterPorts,
  parameter int unsigned NUM_VC       = NumVirtChn,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0][VcWidth-1:0]  vc_id_i,
  input  logic [NUM_REQ-1:0][1:0]          type_i,
  input  logic [NUM_REQ-1:0]               last_i,
  input  logic [NUM_VC-1:0]                vc_ready_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [VcWidth-1:0]               grant_vc_o,
  output logic                             grant_valid_o,
  output logic [NUM_VC-1:0]                lock_o,
  output logic                             stall_err_o
);

  s_arb_lock_t [NUM_VC-1:0]                lock_q, lock_d;
  logic        [NUM_VC-1:0][ReqWidth-1:0]  ptr_q, ptr_d;

  logic [NUM_VC-1:0][NUM_REQ-1:0]  head_req;
  logic [NUM_VC-1:0][NUM_REQ-1:0]  rr_grant;
  logic [NUM_VC-1:0][ReqWidth-1:0] rr_idx;
  logic [NUM_VC-1:0]               rr_valid;

  logic [NUM_VC-1:0]               cand;
  logic [NUM_VC-1:0][NUM_REQ-1:0]  cand_oh;
  logic [NUM_VC-1:0][ReqWidth-1:0] cand_idx;

  logic                sel_valid;
  logic [VcWidth-1:0]  sel_vc;
  logic [NUM_VC-1:0]   xfer_vc;
  logic [NUM_VC-1:0]   force_unlock;

  always_comb begin
    head_req = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        head_req[v][r] = req_i[r] && (vc_id_i[r] == VcWidth'(v)) && (type_i[r] == HEAD_FLIT);
      end
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_rr
    rr_arbiter #(
      .N    (NUM_REQ),
      .IdxW (ReqWidth)
    ) u_rr (
      .req_i         (head_req[v]),
      .ptr_i         (ptr_q[v]),
      .grant_o       (rr_grant[v]),
      .grant_idx_o   (rr_idx[v]),
      .grant_valid_o (rr_valid[v])
    );
  end

  // Locked VCs only listen to their owner's non-HEAD flits; everything else is ignored.
  always_comb begin
    cand     = '0;
    cand_oh  = '0;
    cand_idx = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (lock_q[v].st == ARB_IDLE) begin
        cand[v]     = rr_valid[v];
        cand_oh[v]  = rr_grant[v];
        cand_idx[v] = rr_idx[v];
      end else if (req_i[lock_q[v].owner] &&
                   (vc_id_i[lock_q[v].owner] == VcWidth'(v)) &&
                   (type_i[lock_q[v].owner] != HEAD_FLIT)) begin
        cand[v]                     = 1'b1;
        cand_oh[v][lock_q[v].owner] = 1'b1;
        cand_idx[v]                 = lock_q[v].owner;
      end
    end
  end

  // Ascending scan so the highest ready VC with a candidate is the one left selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (cand[v] && vc_ready_i[v]) begin
        sel_valid = 1'b1;
        sel_vc    = VcWidth'(v);
      end
    end
    grant_valid_o = sel_valid && arst_n;
    grant_o       = grant_valid_o ? cand_oh[sel_vc] : '0;
    grant_vc_o    = grant_valid_o ? sel_vc : '0;
    xfer_vc       = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      xfer_vc[v] = grant_valid_o && (sel_vc == VcWidth'(v));
    end
  end

  always_comb begin
    lock_d = lock_q;
    ptr_d  = ptr_q;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (xfer_vc[v]) begin
        if (lock_q[v].st == ARB_IDLE) begin
          ptr_d[v] = cand_idx[v];
          if (!last_i[cand_idx[v]]) begin
            lock_d[v].st    = ARB_LOCKED;
            lock_d[v].owner = cand_idx[v];
          end
        end else if (type_i[cand_idx[v]] == TAIL_FLIT) begin
          lock_d[v].st = ARB_IDLE;
        end
      end else if (force_unlock[v]) begin
        lock_d[v].st = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        lock_q[v].st    <= ARB_IDLE;
        lock_q[v].owner <= '0;
        ptr_q[v]        <= ReqWidth'(NUM_REQ - 1);
      end
    end else begin
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    lock_o = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      lock_o[v] = (lock_q[v].st == ARB_LOCKED);
    end
  end

`ifdef OUT_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT) + 1;

  logic [NUM_VC-1:0][TimerW-1:0] timer_q, timer_d;
  logic                          stall_err_q;

  always_comb begin
    force_unlock = '0;
    timer_d      = timer_q;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (lock_q[v].st == ARB_IDLE || xfer_vc[v]) begin
        timer_d[v] = '0;
      end else if (timer_q[v] == TimerW'(LOCK_TIMEOUT - 1)) begin
        force_unlock[v] = 1'b1;
        timer_d[v]      = '0;
      end else begin
        timer_d[v] = timer_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      timer_q     <= '0;
      stall_err_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      stall_err_q <= |force_unlock;
    end
  end

  assign stall_err_o = stall_err_q;
`else
  assign force_unlock = '0;
  assign stall_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed packets, a rule-level model and literal checks.
// Build with OUT_ARB_TIMEOUT_EN defined to exercise the forced-unlock path.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  localparam int NR = NumRouterPorts;
  localparam int NV = NumVirtChn;
  localparam int TO = 64;

  logic                        clk = 1'b0;
  logic                        arst_n = 1'b0;
  logic [NR-1:0]               req = '0;
  logic [NR-1:0][VcWidth-1:0]  vc_id = '0;
  logic [NR-1:0][1:0]          typ = '0;
  logic [NR-1:0]               last = '0;
  logic [NV-1:0]               vc_ready = '1;
  logic [NR-1:0]               grant;
  logic [VcWidth-1:0]          grant_vc;
  logic                        grant_valid;
  logic [NV-1:0]               lock;
  logic                        stall_err;

  int total = 0;
  int bad   = 0;

  // Rule-level model state.
  int m_locked [NV];
  int m_owner  [NV];
  int m_ptr    [NV];
  int m_stall  [NV];
  int m_err = 0;
  int m_wv, m_wr, m_errn;
  logic [31:0] m_eg;
  logic [NV-1:0] m_el;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .NUM_REQ      (NR),
    .NUM_VC       (NV),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .req_i         (req),
    .vc_id_i       (vc_id),
    .type_i        (typ),
    .last_i        (last),
    .vc_ready_i    (vc_ready),
    .grant_o       (grant),
    .grant_vc_o    (grant_vc),
    .grant_valid_o (grant_valid),
    .lock_o        (lock),
    .stall_err_o   (stall_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest ready VC with a candidate wins; idle VCs scan HEADs from ptr+1, locked ones take the owner.
  task automatic model_pick(output int wv, output int wr);
    wv = -1;
    wr = -1;
    for (int v = NV - 1; v >= 0 && wr < 0; v--) begin
      if (vc_ready[v]) begin
        if (m_locked[v] != 0) begin
          if (req[m_owner[v]] && int'(vc_id[m_owner[v]]) == v && typ[m_owner[v]] != HEAD_FLIT) begin
            wv = v;
            wr = m_owner[v];
          end
        end else begin
          for (int k = 1; k <= NR && wr < 0; k++) begin
            int r;
            r = (m_ptr[v] + k) % NR;
            if (req[r] && int'(vc_id[r]) == v && typ[r] == HEAD_FLIT) begin
              wv = v;
              wr = r;
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!arst_n) begin
      check("rst_grant", 32'(grant), 0);
      check("rst_valid", 32'(grant_valid), 0);
      check("rst_lock", 32'(lock), 0);
      check("rst_stall", 32'(stall_err), 0);
      for (int v = 0; v < NV; v++) begin
        m_locked[v] = 0;
        m_owner[v]  = 0;
        m_ptr[v]    = NR - 1;
        m_stall[v]  = 0;
      end
      m_err = 0;
    end else begin
      model_pick(m_wv, m_wr);
      m_eg = (m_wr >= 0) ? (32'd1 << m_wr) : 32'd0;
      for (int v = 0; v < NV; v++) m_el[v] = (m_locked[v] != 0);
      check("m_grant", 32'(grant), m_eg);
      check("m_valid", 32'(grant_valid), (m_wr >= 0) ? 1 : 0);
      if (m_wr >= 0) check("m_grant_vc", 32'(grant_vc), 32'(m_wv));
      check("m_lock", 32'(m_el), 32'(m_el) & 32'(lock) | 32'(m_el) & ~32'(lock) | 32'(m_el));
      check("m_lock_exact", 32'(lock), 32'(m_el));
      check("m_stall_err", 32'(stall_err), 32'(m_err));
      m_errn = 0;
`ifdef OUT_ARB_TIMEOUT_EN
      for (int v = 0; v < NV; v++) begin
        if (m_locked[v] != 0 && m_wv != v) begin
          if (m_stall[v] == TO - 1) begin
            m_locked[v] = 0;
            m_stall[v]  = 0;
            m_errn      = 1;
          end else begin
            m_stall[v]++;
          end
        end else begin
          m_stall[v] = 0;
        end
      end
`endif
      if (m_wr >= 0) begin
        if (m_locked[m_wv] == 0) begin
          m_ptr[m_wv] = m_wr;
          if (!last[m_wr]) begin
            m_locked[m_wv] = 1;
            m_owner[m_wv]  = m_wr;
          end
        end else if (typ[m_wr] == TAIL_FLIT) begin
          m_locked[m_wv] = 0;
        end
      end
      m_err = m_errn;
    end
  end

  task automatic clr();
    req   = '0;
    vc_id = '0;
    typ   = '0;
    last  = '0;
  endtask

  task automatic put(input int r, input int v, input logic [1:0] t, input logic l);
    req[r]   = 1'b1;
    vc_id[r] = VcWidth'(v);
    typ[r]   = t;
    last[r]  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] order [6];
    order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b00100;
    order[3] = 5'b01000; order[4] = 5'b10000; order[5] = 5'b00001;

    // Outputs held low in reset even with a HEAD presented.
    put(0, 0, HEAD_FLIT, 1'b1);
    sample();
    check("reset_grant", 32'(grant), 0);
    check("reset_lock", 32'(lock), 0);
    tick();
    arst_n = 1'b1;

    // Single-flit packet.
    clr();
    put(0, 0, HEAD_FLIT, 1'b1);
    sample();
    check("single_grant", 32'(grant), 32'b00001);
    check("single_vc", 32'(grant_vc), 0);
    tick();
    clr();
    put(2, 0, BODY_FLIT, 1'b0);
    sample();
    check("single_nolock", 32'(lock), 0);
    check("body_on_idle", 32'(grant), 0);
    tick();

    // Contention on vc0.
    do_reset();
    put(1, 0, HEAD_FLIT, 1'b0);
    put(3, 0, HEAD_FLIT, 1'b0);
    sample();
    check("cont_head", 32'(grant), 32'b00010);
    tick();
    put(1, 0, BODY_FLIT, 1'b0);
    sample();
    check("cont_body", 32'(grant), 32'b00010);
    check("cont_lock", 32'(lock), 32'b01);
    tick();
    put(1, 0, TAIL_FLIT, 1'b0);
    sample();
    check("cont_tail", 32'(grant), 32'b00010);
    tick();
    clr();
    put(3, 0, HEAD_FLIT, 1'b0);
    sample();
    check("cont_unlock", 32'(lock), 0);
    check("cont_req3", 32'(grant), 32'b01000);
    tick();
    put(3, 0, TAIL_FLIT, 1'b0);
    sample();
    check("cont_req3_tail", 32'(grant), 32'b01000);
    tick();

    // Wormhole on vc1 with an interloper.
    do_reset();
    put(2, 1, HEAD_FLIT, 1'b0);
    sample();
    check("worm_head", 32'(grant), 32'b00100);
    check("worm_vc", 32'(grant_vc), 1);
    tick();
    put(2, 1, BODY_FLIT, 1'b0);
    put(4, 1, BODY_FLIT, 1'b0);
    sample();
    check("worm_body1", 32'(grant), 32'b00100);
    check("worm_lock", 32'(lock), 32'b10);
    tick();
    clr();
    put(4, 1, BODY_FLIT, 1'b0);
    sample();
    check("worm_intruder", 32'(grant), 0);
    tick();
    put(2, 1, BODY_FLIT, 1'b0);
    sample();
    check("worm_body2", 32'(grant), 32'b00100);
    tick();
    put(2, 1, TAIL_FLIT, 1'b0);
    put(4, 1, HEAD_FLIT, 1'b1);
    sample();
    check("worm_tail", 32'(grant), 32'b00100);
    check("worm_lock_hold", 32'(lock), 32'b10);
    tick();
    clr();
    put(4, 1, HEAD_FLIT, 1'b1);
    sample();
    check("worm_lock_fall", 32'(lock), 0);
    check("worm_next", 32'(grant), 32'b10000);
    tick();

    // VC priority.
    do_reset();
    put(0, 0, HEAD_FLIT, 1'b1);
    put(1, 1, HEAD_FLIT, 1'b1);
    sample();
    check("prio_hi", 32'(grant), 32'b00010);
    check("prio_hi_vc", 32'(grant_vc), 1);
    tick();
    vc_ready = 2'b01;
    sample();
    check("prio_lo", 32'(grant), 32'b00001);
    check("prio_lo_vc", 32'(grant_vc), 0);
    tick();
    vc_ready = 2'b00;
    sample();
    check("prio_none", 32'(grant_valid), 0);
    tick();
    vc_ready = '1;

    // Fairness: back-to-back single-flit HEADs from all requesters.
    do_reset();
    for (int r = 0; r < NR; r++) put(r, 0, HEAD_FLIT, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("fair_%0d", i), 32'(grant), 32'(order[i]));
      tick();
    end

    // Reset mid-packet drops the lock at once.
    do_reset();
    put(0, 1, HEAD_FLIT, 1'b0);
    tick();
    clr();
    #1;
    check("mid_locked", 32'(lock), 32'b10);
    arst_n = 1'b0;
    #1;
    check("mid_rst_lock", 32'(lock), 0);
    tick();
    tick();
    arst_n = 1'b1;

    // Stalled owner.
    clr();
    put(0, 0, HEAD_FLIT, 1'b0);
    sample();
    check("to_head", 32'(grant), 32'b00001);
    tick();
    clr();
    put(3, 0, HEAD_FLIT, 1'b1);
    sample();
    check("to_locked", 32'(lock), 32'b01);
    check("to_blocked", 32'(grant), 0);
    for (int i = 0; i < TO; i++) tick();
    sample();
`ifdef OUT_ARB_TIMEOUT_EN
    check("to_unlock", 32'(lock), 0);
    check("to_pulse", 32'(stall_err), 1);
    check("to_regrant", 32'(grant), 32'b01000);
`else
    check("to_hold", 32'(lock), 32'b01);
    check("to_nopulse", 32'(stall_err), 0);
    check("to_still_blocked", 32'(grant), 0);
`endif
    tick();
    clr();
    sample();
    check("to_pulse_end", 32'(stall_err), 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
